add32_rr_seq: RTL and testbench

Two-requester, round-robin-arbitrated sequencer that performs 32-bit additions on a shared 8-bit carry-lookahead slice over four byte beats. The slice is two chained `cla4` instances: the low instance's `co` feeds the high instance's `ci`. The block sits beside the counter and accumulator logic in `cntr8`, so several clients can use one small adder without each carrying a 32-bit adder. It owns arbitration, operand capture, beat counting, inter-beat carry storage and result presentation.

---
 rtl/add32_rr_seq_if.sv | 28 ++
 rtl/add32_rr_seq.sv | 159 +++++++++++++++
 tb/tb_add32_rr_seq.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/add32_rr_seq_if.sv
// Request/response bundle for add32_rr_seq: two requesters' operands and
// handshakes on one side, the registered result presentation on the other.
interface add32_rr_seq_if;
   logic        req0;
   logic [31:0] a0;
   logic [31:0] b0;
   logic        ci0;
   logic        req1;
   logic [31:0] a1;
   logic [31:0] b1;
   logic        ci1;
   logic        gnt0;
   logic        gnt1;
   logic        done;
   logic        done_id;
   logic [31:0] result;
   logic        co;

   modport master (
      output req0, a0, b0, ci0, req1, a1, b1, ci1,
      input  gnt0, gnt1, done, done_id, result, co
   );

   modport slave (
      input  req0, a0, b0, ci0, req1, a1, b1, ci1,
      output gnt0, gnt1, done, done_id, result, co
   );
endinterface

// File: rtl/add32_rr_seq.sv
// add32_rr_seq: round-robin shared 32-bit adder built on an 8-bit carry-lookahead
// slice (two chained cla4) that processes one operand byte per cycle.

// 4-bit carry-lookahead adder.
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [3:0] p;
   logic [3:0] g;
   logic [3:0] c;

   // Generate/propagate terms and flattened lookahead carries.
   always_comb begin
      p    = a ^ b;
      g    = a & b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      s    = p ^ c;
   end
endmodule

module add32_rr_seq (
   input logic           clk,
   input logic           reset_n,
   add32_rr_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q;
   logic        last_q;
   logic        id_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic        carry_q;
   logic [1:0]  beat_q;
   logic [31:0] sum_q;
   logic [31:0] sum_d;
   logic [31:0] result_q;
   logic        co_q;
   logic        done_q;
   logic        done_id_q;
   logic        gnt0_q;
   logic        gnt1_q;

   logic [7:0]  slice_a;
   logic [7:0]  slice_b;
   logic [7:0]  slice_sum;
   logic        slice_mid;
   logic        slice_co;
   logic        win1_d;

   // Select the current operand byte for the shared slice.
   always_comb begin
      slice_a = a_q[{beat_q, 3'b000} +: 8];
      slice_b = b_q[{beat_q, 3'b000} +: 8];
   end

   cla4 u_cla_lo (
      .a  (slice_a[3:0]),
      .b  (slice_b[3:0]),
      .ci (carry_q),
      .s  (slice_sum[3:0]),
      .co (slice_mid)
   );

   cla4 u_cla_hi (
      .a  (slice_a[7:4]),
      .b  (slice_b[7:4]),
      .ci (slice_mid),
      .s  (slice_sum[7:4]),
      .co (slice_co)
   );

   // Working sum with the current beat's byte merged in; on the last beat this
   // is the complete result, so it feeds both sum_q and result_q.
   always_comb begin
      sum_d = sum_q;
      sum_d[{beat_q, 3'b000} +: 8] = slice_sum;
   end

   // Requester 1 wins when alone, or on a tie when requester 0 won last time.
   always_comb begin
      win1_d = bus.req1 & (~bus.req0 | ~last_q);
   end

   // Sequencer: arbitration/capture, four byte beats, one-cycle done.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         id_q      <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         carry_q   <= 1'b0;
         beat_q    <= '0;
         sum_q     <= '0;
         result_q  <= '0;
         co_q      <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
      end else begin
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  if (win1_d) begin
                     a_q     <= bus.a1;
                     b_q     <= bus.b1;
                     carry_q <= bus.ci1;
                     gnt1_q  <= 1'b1;
                  end else begin
                     a_q     <= bus.a0;
                     b_q     <= bus.b0;
                     carry_q <= bus.ci0;
                     gnt0_q  <= 1'b1;
                  end
                  id_q    <= win1_d;
                  last_q  <= win1_d;
                  beat_q  <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               sum_q   <= sum_d;
               carry_q <= slice_co;
               beat_q  <= beat_q + 2'd1;
               if (beat_q == 2'd3) begin
                  result_q  <= sum_d;
                  co_q      <= slice_co;
                  done_id_q <= id_q;
                  done_q    <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.gnt0    = gnt0_q;
   assign bus.gnt1    = gnt1_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
   assign bus.result  = result_q;
   assign bus.co      = co_q;
endmodule

// File: tb/tb_add32_rr_seq.sv
// Self-checking bench for add32_rr_seq: directed scenarios plus a randomized
// back-to-back run against an arithmetic/round-robin reference model.
module tb_add32_rr_seq;
   logic clk = 1'b0;
   logic reset_n;
   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   add32_rr_seq_if bus();

   add32_rr_seq dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Reference: plain 33-bit unsigned addition.
   function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic ci);
      return {1'b0, a} + {1'b0, b} + {32'd0, ci};
   endfunction

   task automatic drop_reqs();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drop_reqs();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Drive one request, drop it at grant, report what was observed.
   task automatic run_op(input logic sel, input logic [31:0] a, input logic [31:0] b, input logic ci,
                         output logic g0, output logic g1, output int lat,
                         output logic [31:0] r, output logic c, output logic id);
      int n;
      @(negedge clk);
      if (sel) begin bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.ci1 = ci; end
      else     begin bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.ci0 = ci; end
      n = 0;
      do begin @(negedge clk); n++; end while (!(bus.gnt0 || bus.gnt1) && n < 12);
      g0 = bus.gnt0;
      g1 = bus.gnt1;
      drop_reqs();
      lat = 0;
      while (!bus.done && lat < 12) begin @(negedge clk); lat++; end
      r  = bus.result;
      c  = bus.co;
      id = bus.done_id;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drop_reqs();
      bus.a0 = '0; bus.b0 = '0; bus.ci0 = 1'b0;
      bus.a1 = '0; bus.b1 = '0; bus.ci1 = 1'b0;
      repeat (3) @(negedge clk);
      n_total++; if ({bus.gnt0, bus.gnt1, bus.done, bus.done_id, bus.co} !== 5'b0) $display("FAIL reset_flags: got %b exp 00000", {bus.gnt0, bus.gnt1, bus.done, bus.done_id, bus.co}); else n_pass++;
      n_total++; if (bus.result !== 32'h0) $display("FAIL reset_result: got %h exp 00000000", bus.result); else n_pass++;
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      n_total++; if ({bus.gnt0, bus.gnt1, bus.done} !== 3'b0) $display("FAIL idle_quiet: got %b exp 000", {bus.gnt0, bus.gnt1, bus.done}); else n_pass++;
   endtask

   task automatic test_single();
      logic g0, g1, c, id; int lat; logic [31:0] r;
      run_op(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, g0, g1, lat, r, c, id);
      n_total++; if ({g0, g1} !== 2'b10) $display("FAIL single_gnt: got g0g1=%b exp 10", {g0, g1}); else n_pass++;
      n_total++; if (lat !== 4) $display("FAIL single_latency: got %0d exp 4", lat); else n_pass++;
      n_total++; if (r !== 32'h0000_0100) $display("FAIL single_result: got %h exp 00000100", r); else n_pass++;
      n_total++; if ({c, id} !== 2'b00) $display("FAIL single_co_id: got %b exp 00", {c, id}); else n_pass++;
      n_total++; if (bus.done !== 1'b0) $display("FAIL single_done_pulse: got %b exp 0", bus.done); else n_pass++;
   endtask

   task automatic test_cross_carry();
      logic g0, g1, c, id; int lat; logic [31:0] r;
      run_op(1'b1, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, g0, g1, lat, r, c, id);
      n_total++; if ({g0, g1} !== 2'b01) $display("FAIL carry1_gnt: got g0g1=%b exp 01", {g0, g1}); else n_pass++;
      n_total++; if (r !== 32'h0100_0000) $display("FAIL carry1_result: got %h exp 01000000", r); else n_pass++;
      n_total++; if ({c, id} !== 2'b01) $display("FAIL carry1_co_id: got %b exp 01", {c, id}); else n_pass++;
      run_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, g0, g1, lat, r, c, id);
      n_total++; if (r !== 32'h0000_0000) $display("FAIL carry2_result: got %h exp 00000000", r); else n_pass++;
      n_total++; if ({c, id} !== 2'b11) $display("FAIL carry2_co_id: got %b exp 11", {c, id}); else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [32:0] exp_q[$];
      logic        id_q[$];
      int          grants = 0, dones = 0, last_g = -1, cyc = 0;
      logic [32:0] e; logic ei;
      do_reset();
      bus.req0 = 1'b1; bus.a0 = 32'h1111_1111; bus.b0 = 32'h0F0F_0F0F; bus.ci0 = 1'b1;
      bus.req1 = 1'b1; bus.a1 = 32'h8000_0000; bus.b1 = 32'h8000_0001; bus.ci1 = 1'b0;
      while (dones < 4 && cyc < 80) begin
         @(negedge clk); cyc++;
         if (bus.gnt0 || bus.gnt1) begin
            n_total++; if ({bus.gnt0, bus.gnt1} !== ((grants % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL rr_order: grant %0d got g0g1=%b", grants, {bus.gnt0, bus.gnt1}); else n_pass++;
            if (last_g >= 0) begin
               n_total++; if (cyc - last_g !== 6) $display("FAIL rr_spacing: got %0d exp 6", cyc - last_g); else n_pass++;
            end
            last_g = cyc;
            if (bus.gnt1) begin
               exp_q.push_back(ref_add(bus.a1, bus.b1, bus.ci1)); id_q.push_back(1'b1);
               bus.a1 = $urandom; bus.b1 = $urandom; bus.ci1 = 1'($urandom);
            end else begin
               exp_q.push_back(ref_add(bus.a0, bus.b0, bus.ci0)); id_q.push_back(1'b0);
               bus.a0 = $urandom; bus.b0 = $urandom; bus.ci0 = 1'($urandom);
            end
            grants++;
            if (grants == 4) drop_reqs();
         end
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               n_total++; $display("FAIL rr_stray_done: got done exp none");
            end else begin
               e = exp_q.pop_front(); ei = id_q.pop_front();
               n_total++; if ({bus.co, bus.result} !== e) $display("FAIL rr_result: got %h exp %h", {bus.co, bus.result}, e); else n_pass++;
               n_total++; if (bus.done_id !== ei) $display("FAIL rr_done_id: got %b exp %b", bus.done_id, ei); else n_pass++;
            end
            dones++;
         end
      end
      n_total++; if (dones !== 4) $display("FAIL rr_timeout: got %0d dones exp 4", dones); else n_pass++;
      drop_reqs();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_operand_independence();
      logic [32:0] e; int n;
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      e = ref_add(a, b, 1'b1);
      @(negedge clk);
      bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.ci0 = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.gnt0 && n < 12);
      bus.req0 = 1'b0;
      @(negedge clk);
      bus.a0 = ~a; bus.b0 = $urandom; bus.ci0 = 1'b0;
      n = 1;
      while (!bus.done && n < 12) begin @(negedge clk); n++; end
      n_total++; if (n !== 4) $display("FAIL indep_latency: got %0d exp 4", n); else n_pass++;
      n_total++; if ({bus.co, bus.result} !== e) $display("FAIL indep_result: got %h exp %h", {bus.co, bus.result}, e); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n; logic stray; logic [32:0] e;
      @(negedge clk);
      bus.req1 = 1'b1; bus.a1 = 32'hDEAD_BEEF; bus.b1 = 32'h1234_5678; bus.ci1 = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.gnt1 && n < 12);
      drop_reqs();
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_total++; if ({bus.gnt0, bus.gnt1, bus.done, bus.done_id, bus.co} !== 5'b0) $display("FAIL midreset_flags: got %b exp 00000", {bus.gnt0, bus.gnt1, bus.done, bus.done_id, bus.co}); else n_pass++;
      n_total++; if (bus.result !== 32'h0) $display("FAIL midreset_result: got %h exp 00000000", bus.result); else n_pass++;
      bus.req0 = 1'b1; bus.a0 = 32'h0000_FFFF; bus.b0 = 32'h0000_0001; bus.ci0 = 1'b1;
      bus.req1 = 1'b1; bus.a1 = 32'h7777_7777; bus.b1 = 32'h1; bus.ci1 = 1'b0;
      e = ref_add(32'h0000_FFFF, 32'h0000_0001, 1'b1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      stray = 1'b0; n = 0;
      do begin @(negedge clk); n++; if (bus.done) stray = 1'b1; end while (!(bus.gnt0 || bus.gnt1) && n < 12);
      n_total++; if ({bus.gnt0, bus.gnt1} !== 2'b10) $display("FAIL midreset_first_gnt: got g0g1=%b exp 10", {bus.gnt0, bus.gnt1}); else n_pass++;
      drop_reqs();
      n = 0;
      while (!bus.done && n < 12) begin @(negedge clk); n++; end
      n_total++; if (stray !== 1'b0) $display("FAIL midreset_stray_done: got %b exp 0", stray); else n_pass++;
      n_total++; if (n !== 4) $display("FAIL midreset_latency: got %0d exp 4", n); else n_pass++;
      n_total++; if ({bus.co, bus.result, bus.done_id} !== {e, 1'b0}) $display("FAIL midreset_result2: got %h exp %h", {bus.co, bus.result, bus.done_id}, {e, 1'b0}); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_hold();
      logic g0, g1, c, id; int lat; logic [31:0] r;
      run_op(1'b0, 32'h1234_5670, 32'h0000_0008, 1'b0, g0, g1, lat, r, c, id);
      n_total++; if (r !== 32'h1234_5678) $display("FAIL hold_initial: got %h exp 12345678", r); else n_pass++;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_total++; if ({bus.done, bus.result, bus.co, bus.done_id} !== {1'b0, 32'h1234_5678, 2'b00}) $display("FAIL hold_cycle%0d: got %h exp %h", i, {bus.done, bus.result, bus.co, bus.done_id}, {1'b0, 32'h1234_5678, 2'b00}); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [32:0] exp_q[$];
      logic        id_q[$];
      int          t_q[$];
      logic        last, w;
      logic [32:0] e; logic ei; int t;
      do_reset();
      last = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (bus.gnt0 || bus.gnt1) begin
            if (!bus.req0 && !bus.req1) begin
               n_total++; $display("FAIL b2b_unrequested_gnt: got g0g1=%b exp 00", {bus.gnt0, bus.gnt1});
            end else begin
               w = (bus.req0 && bus.req1) ? ~last : bus.req1;
               last = w;
               n_total++; if ({bus.gnt0, bus.gnt1} !== (w ? 2'b01 : 2'b10)) $display("FAIL b2b_winner: got g0g1=%b exp %b", {bus.gnt0, bus.gnt1}, w ? 2'b01 : 2'b10); else n_pass++;
               if (w) begin exp_q.push_back(ref_add(bus.a1, bus.b1, bus.ci1)); bus.req1 = 1'b0; end
               else   begin exp_q.push_back(ref_add(bus.a0, bus.b0, bus.ci0)); bus.req0 = 1'b0; end
               id_q.push_back(w);
               t_q.push_back(cyc);
            end
         end
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               n_total++; $display("FAIL b2b_stray_done: got done exp none");
            end else begin
               e = exp_q.pop_front(); ei = id_q.pop_front(); t = t_q.pop_front();
               n_total++; if ({bus.co, bus.result, bus.done_id} !== {e, ei}) $display("FAIL b2b_result: got %h exp %h", {bus.co, bus.result, bus.done_id}, {e, ei}); else n_pass++;
               n_total++; if (cyc - t !== 4) $display("FAIL b2b_latency: got %0d exp 4", cyc - t); else n_pass++;
            end
         end
         if (cyc < 360) begin
            if (!bus.req0 && $urandom_range(0, 2) == 0) begin
               bus.req0 = 1'b1;
               bus.a0 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
               bus.b0 = $urandom; bus.ci0 = 1'($urandom);
            end
            if (!bus.req1 && $urandom_range(0, 2) == 0) begin
               bus.req1 = 1'b1;
               bus.a1 = $urandom;
               bus.b1 = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : 32'($urandom);
               bus.ci1 = 1'($urandom);
            end
         end
      end
      n_total++; if ({bus.req0, bus.req1} !== 2'b00 || exp_q.size() != 0) $display("FAIL b2b_drain: got pending=%0d reqs=%b exp 0 00", exp_q.size(), {bus.req0, bus.req1}); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_cross_carry();
      test_round_robin();
      test_operand_independence();
      test_reset_mid();
      test_hold();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
